// File: rtl/dmem_mmio.sv
// Data-side responder for the single-cycle MIPS core: word-addressed RAM plus an MMIO window
// (TX FIFO, status, cycle counter, done/result). Define DMEM_WRITE_TRACE_EN to build the TRACE register.
module dmem_mmio #(
  parameter int unsigned RAM_WORDS  = 64,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        tx_valid,
  output logic [31:0] tx_data,
  input  logic        tx_ready,
  output logic        done,
  output logic [31:0] result
);

  localparam int unsigned AW = $clog2(RAM_WORDS);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [2:0] {
    REG_TXDATA = 3'd0,
    REG_STATUS = 3'd1,
    REG_CYCLES = 3'd2,
    REG_DONE   = 3'd3,
    REG_TRACE  = 3'd4
  } mmio_reg_e;

  logic          is_mmio;
  logic [AW-1:0] ram_idx;
  logic [2:0]    reg_sel;
  logic          ram_we;
  logic          tx_we;
  logic          done_we;
  logic          unused_addr;

  assign is_mmio     = dataadr[31];
  assign ram_idx     = dataadr[AW+1:2];
  assign reg_sel     = dataadr[4:2];
  assign ram_we      = memwrite & ~is_mmio;
  assign tx_we       = memwrite & is_mmio & (reg_sel == REG_TXDATA);
  assign done_we     = memwrite & is_mmio & (reg_sel == REG_DONE);
  assign unused_addr = ^{dataadr[30:5], dataadr[1:0]};

  // RAM is deliberately left out of reset; a write coinciding with reset is dropped.
  logic [31:0] ram [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (!reset && ram_we) begin
      ram[ram_idx] <= writedata;
    end
  end

  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic          empty;
  logic          full;
  logic          do_pop;
  logic          do_push;

  assign empty    = (count == '0);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign do_pop   = ~empty & tx_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push  = tx_we & (~full | do_pop);
  assign tx_valid = ~empty;
  assign tx_data  = empty ? '0 : fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      fifo_mem[wr_ptr] <= writedata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
      if (tx_we && full && !do_pop) begin
        overflow <= 1'b1;
      end
    end
  end

  logic [31:0] cycles;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycles <= '0;
    end else begin
      cycles <= cycles + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done   <= 1'b0;
      result <= '0;
    end else if (done_we) begin
      done   <= 1'b1;
      result <= writedata;
    end
  end

`ifdef DMEM_WRITE_TRACE_EN
  logic [15:0] trace_cnt;
  logic [15:0] trace_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      trace_cnt <= '0;
      trace_idx <= '0;
    end else if (ram_we) begin
      trace_cnt <= trace_cnt + 1'b1;
      trace_idx <= 16'(ram_idx);
    end
  end
`endif

  logic [31:0] status;
  assign status = {16'h0000, 8'(count), 5'b00000, overflow, full, empty};

  always_comb begin
    readdata = '0;
    if (!is_mmio) begin
      readdata = ram[ram_idx];
    end else begin
      case (reg_sel)
        REG_STATUS: readdata = status;
        REG_CYCLES: readdata = cycles;
        REG_DONE:   readdata = result;
`ifdef DMEM_WRITE_TRACE_EN
        REG_TRACE:  readdata = {trace_idx, trace_cnt};
`endif
        default:    readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: directed scenarios plus randomized traffic against a
// queue/array reference model. Honours DMEM_WRITE_TRACE_EN for the TRACE register.
module tb_dmem_mmio;

  localparam int unsigned RAM_WORDS  = 64;
  localparam int unsigned FIFO_DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready = 1'b0;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_mmio #(.RAM_WORDS(RAM_WORDS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .readdata(readdata), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_ready(tx_ready), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_ram [RAM_WORDS];
  logic [31:0] m_q [$];
  bit          m_ovf;
  logic [31:0] m_cyc;
  bit          m_done;
  logic [31:0] m_result;
  int unsigned m_tcnt;
  int unsigned m_tidx;

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int unsigned sel;
    int unsigned n;
    if (a[31] == 1'b0) return m_ram[(a >> 2) % RAM_WORDS];
    sel = (a >> 2) % 8;
    n = m_q.size();
    case (sel)
      1: return 32'(n * 256 + (m_ovf ? 4 : 0) + (n == FIFO_DEPTH ? 2 : 0) + (n == 0 ? 1 : 0));
      2: return m_cyc;
      3: return m_result;
`ifdef DMEM_WRITE_TRACE_EN
      4: return 32'(m_tidx * 65536 + m_tcnt);
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge();
    int unsigned sel;
    bit pop;
    bit push;
    int unsigned n;
    if (reset) begin
      m_q.delete();
      m_ovf = 0; m_cyc = 0; m_done = 0; m_result = 0; m_tcnt = 0; m_tidx = 0;
      return;
    end
    sel  = (dataadr >> 2) % 8;
    n    = m_q.size();
    pop  = (n != 0) && tx_ready;
    push = memwrite && dataadr[31] && sel == 0;
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (n < FIFO_DEPTH || pop) m_q.push_back(writedata);
      else m_ovf = 1;
    end
    if (memwrite && !dataadr[31]) begin
      m_ram[(dataadr >> 2) % RAM_WORDS] = writedata;
      m_tcnt = (m_tcnt + 1) % 65536;
      m_tidx = (dataadr >> 2) % RAM_WORDS;
    end
    if (memwrite && dataadr[31] && sel == 3) begin
      m_done = 1;
      m_result = writedata;
    end
    m_cyc = m_cyc + 1;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; memwrite = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    dataadr = 32'h8000_0004;
    #1;
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
    n_checks++; if (tx_data !== 32'h0) begin n_fail++; $display("FAIL reset_tx_data: got %h expected 0", tx_data); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", result); end
    n_checks++; if (readdata !== 32'h1) begin n_fail++; $display("FAIL reset_status: got %h expected 00000001", readdata); end
    dataadr = 32'h8000_0008;
    #1;
    n_checks++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL reset_cycles: got %h expected 0", readdata); end
  endtask

  task automatic test_ram();
    memwrite = 1'b1; dataadr = 32'h54; writedata = 32'd34;
    step();
    memwrite = 1'b0;
    #1;
    n_checks++; if (readdata !== 32'd34) begin n_fail++; $display("FAIL ram_lw: got %h expected %h", readdata, 32'd34); end
    memwrite = 1'b1; dataadr = 32'h154; writedata = 32'd99;
    #1;
    n_checks++; if (readdata !== 32'd34) begin n_fail++; $display("FAIL ram_prewrite: got %h expected %h", readdata, 32'd34); end
    step();
    memwrite = 1'b0; dataadr = 32'h54;
    #1;
    n_checks++; if (readdata !== 32'd99) begin n_fail++; $display("FAIL ram_alias: got %h expected %h", readdata, 32'd99); end
    reset = 1'b1; memwrite = 1'b1; writedata = 32'hDEAD;
    step();
    reset = 1'b0; memwrite = 1'b0;
    #1;
    n_checks++; if (readdata !== 32'd99) begin n_fail++; $display("FAIL ram_reset_discard: got %h expected %h", readdata, 32'd99); end
  endtask

  task automatic test_fifo_overflow();
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      memwrite = 1'b1; dataadr = 32'h8000_0000; writedata = 32'hA1 + 32'(i);
      step();
    end
    memwrite = 1'b0; dataadr = 32'h8000_0004;
    #1;
    n_checks++; if (readdata !== 32'h0806) begin n_fail++; $display("FAIL ovf_status: got %h expected 00000806", readdata); end
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_checks++;
      if (tx_valid !== 1'b1 || tx_data !== 32'hA1 + 32'(i)) begin
        n_fail++; $display("FAIL ovf_drain[%0d]: got v=%b d=%h expected v=1 d=%h", i, tx_valid, tx_data, 32'hA1 + 32'(i));
      end
      step();
    end
    #1;
    n_checks++; if (tx_valid !== 1'b0 || tx_data !== 32'h0) begin n_fail++; $display("FAIL ovf_empty: got v=%b d=%h expected v=0 d=0", tx_valid, tx_data); end
    n_checks++; if (readdata !== 32'h0005) begin n_fail++; $display("FAIL ovf_status_empty: got %h expected 00000005", readdata); end
    tx_ready = 1'b0;
  endtask

  task automatic test_fifo_pushpop();
    logic [31:0] exp;
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      memwrite = 1'b1; dataadr = 32'h8000_0000; writedata = 32'hB0 + 32'(i);
      step();
    end
    memwrite = 1'b0; dataadr = 32'h8000_0004;
    #1;
    n_checks++; if (readdata !== 32'h0802) begin n_fail++; $display("FAIL full_status: got %h expected 00000802", readdata); end
    memwrite = 1'b1; dataadr = 32'h8000_0000; writedata = 32'hC0; tx_ready = 1'b1;
    step();
    memwrite = 1'b0; tx_ready = 1'b0; dataadr = 32'h8000_0004;
    #1;
    n_checks++; if (readdata !== 32'h0802) begin n_fail++; $display("FAIL full_pushpop_status: got %h expected 00000802", readdata); end
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp = (i < 7) ? 32'hB1 + 32'(i) : 32'hC0;
      #1;
      n_checks++; if (tx_data !== exp) begin n_fail++; $display("FAIL full_drain[%0d]: got %h expected %h", i, tx_data, exp); end
      step();
    end
    memwrite = 1'b1; dataadr = 32'h8000_0000; writedata = 32'hD0;
    #1;
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL empty_pushpop_valid: got %b expected 0", tx_valid); end
    step();
    memwrite = 1'b0;
    #1;
    n_checks++; if (tx_valid !== 1'b1 || tx_data !== 32'hD0) begin n_fail++; $display("FAIL empty_pushpop_data: got v=%b d=%h expected v=1 d=000000d0", tx_valid, tx_data); end
    step();
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL empty_pushpop_drained: got %b expected 0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_cycles();
    do_reset();
    dataadr = 32'h8000_0008;
    #1;
    n_checks++; if (readdata !== 32'd0) begin n_fail++; $display("FAIL cycles_start: got %h expected 0", readdata); end
    repeat (10) step();
    n_checks++; if (readdata !== 32'd10) begin n_fail++; $display("FAIL cycles_10: got %h expected %h", readdata, 32'd10); end
    memwrite = 1'b1; writedata = 32'h0;
    step();
    memwrite = 1'b0;
    #1;
    n_checks++; if (readdata !== 32'd11) begin n_fail++; $display("FAIL cycles_ro: got %h expected %h", readdata, 32'd11); end
    force dut.cycles = 32'hFFFF_FFFF;
    #1;
    n_checks++; if (readdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL cycles_forced: got %h expected ffffffff", readdata); end
    release dut.cycles;
    step();
    n_checks++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL cycles_wrap: got %h expected 0", readdata); end
  endtask

  task automatic test_done();
    do_reset();
    memwrite = 1'b1; dataadr = 32'h8000_000C; writedata = 32'h1234;
    #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_before: got %b expected 0", done); end
    step();
    memwrite = 1'b0;
    #1;
    n_checks++; if (done !== 1'b1 || result !== 32'h1234) begin n_fail++; $display("FAIL done_first: got done=%b result=%h expected done=1 result=00001234", done, result); end
    n_checks++; if (readdata !== 32'h1234) begin n_fail++; $display("FAIL done_read: got %h expected 00001234", readdata); end
    memwrite = 1'b1; writedata = 32'h5;
    step();
    memwrite = 1'b0;
    #1;
    n_checks++; if (done !== 1'b1 || result !== 32'h5) begin n_fail++; $display("FAIL done_second: got done=%b result=%h expected done=1 result=00000005", done, result); end
    memwrite = 1'b1; dataadr = 32'h8000_0014; writedata = 32'hFFFF;
    step();
    memwrite = 1'b0;
    #1;
    n_checks++; if (readdata !== 32'h0 || result !== 32'h5) begin n_fail++; $display("FAIL unmapped: got rd=%h result=%h expected rd=0 result=00000005", readdata, result); end
    do_reset();
    #1;
    n_checks++; if (done !== 1'b0 || result !== 32'h0) begin n_fail++; $display("FAIL done_reset: got done=%b result=%h expected done=0 result=0", done, result); end
  endtask

  task automatic test_trace();
    logic [31:0] seq [5];
    logic [31:0] exp;
    seq[0] = 32'h10; seq[1] = 32'h14; seq[2] = 32'h8000_0010; seq[3] = 32'h8000_0014; seq[4] = 32'h114;
    do_reset();
    foreach (seq[i]) begin
      memwrite = 1'b1; dataadr = seq[i]; writedata = 32'h77 + 32'(i);
      step();
    end
    memwrite = 1'b0; dataadr = 32'h8000_0010;
    #1;
`ifdef DMEM_WRITE_TRACE_EN
    exp = 32'h0005_0003;
`else
    exp = 32'h0;
`endif
    n_checks++; if (readdata !== exp) begin n_fail++; $display("FAIL trace: got %h expected %h", readdata, exp); end
  endtask

  task automatic test_random();
    logic [31:0] exp;
    int unsigned ready_pct;
    do_reset();
    for (int i = 0; i < RAM_WORDS; i++) begin
      memwrite = 1'b1; dataadr = 32'(i * 4); writedata = $urandom;
      step();
    end
    memwrite = 1'b0;
    for (int i = 0; i < 800; i++) begin
      ready_pct = ((i / 100) % 2 == 0) ? 20 : 80;
      reset     = ($urandom_range(0, 99) == 0);
      memwrite  = $urandom_range(0, 1);
      tx_ready  = ($urandom_range(0, 99) < ready_pct);
      writedata = $urandom;
      if ($urandom_range(0, 1) == 0) dataadr = {1'b0, 31'($urandom)};
      else if ($urandom_range(0, 1) == 0) dataadr = {1'b1, 26'($urandom), 3'd0, 2'($urandom)};
      else dataadr = {1'b1, 26'($urandom), 3'($urandom_range(0, 7)), 2'($urandom)};
      #1;
      exp = model_read(dataadr);
      n_checks++; if (readdata !== exp) begin n_fail++; $display("FAIL rnd_readdata[%0d]: addr=%h got %h expected %h", i, dataadr, readdata, exp); end
      n_checks++; if (tx_valid !== (m_q.size() != 0)) begin n_fail++; $display("FAIL rnd_tx_valid[%0d]: got %b expected %b", i, tx_valid, m_q.size() != 0); end
      exp = (m_q.size() != 0) ? m_q[0] : 32'h0;
      n_checks++; if (tx_data !== exp) begin n_fail++; $display("FAIL rnd_tx_data[%0d]: got %h expected %h", i, tx_data, exp); end
      n_checks++; if (done !== m_done || result !== m_result) begin n_fail++; $display("FAIL rnd_done[%0d]: got done=%b result=%h expected done=%b result=%h", i, done, result, m_done, m_result); end
      step();
    end
    reset = 1'b0; memwrite = 1'b0; tx_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ram();
    test_fifo_overflow();
    test_fifo_pushpop();
    test_cycles();
    test_done();
    test_trace();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_mmio.md
Name: dmem_mmio

Overview:
Data-side responder for the single-cycle MIPS core. It is the far end of the core's memwrite/dataadr/writedata bus. Low addresses map to a word-addressed data RAM. Addresses with bit 31 set map to a small MMIO window containing:
- a TX FIFO, drained over a valid/ready stream;
- a status register;
- a free-running cycle counter;
- a done/result register that benches and off-chip logic watch for pass/fail.

Parameters:
RAM_WORDS, 64, data RAM depth in 32-bit words; power of two.
FIFO_DEPTH, 8, TX FIFO depth in words; power of two, minimum 2.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
memwrite  input  1  write strobe from core; sampled on rising clk.
dataadr  input  32  byte address from core.
writedata  input  32  store data from core.
readdata  output  32  load data to core; combinational.
tx_valid  output  1  TX FIFO head valid.
tx_data  output  32  TX FIFO head word.
tx_ready  input  1  consumer accepts head when tx_valid && tx_ready at rising clk.
done  output  1  sticky; set by write to DONE register.
result  output  32  value written to DONE register.

Behaviour:
Address decode:
- dataadr[1:0] ignored; all accesses are whole words.
- dataadr[31]=0: RAM, index = dataadr[log2(RAM_WORDS)+1:2]. Higher bits are ignored, so the index wraps modulo RAM_WORDS.
- dataadr[31]=1: MMIO, register selected by dataadr[4:2]:
  - 0 TXDATA: write only; reads 0.
  - 1 STATUS: read only. bits [15:8] = fifo count, bit2 = overflow (sticky), bit1 = full, bit0 = empty. All other bits 0.
  - 2 CYCLES: read only; 32-bit count of cycles since reset.
  - 3 DONE: write sets done=1 and result=writedata. Reads return result.
  - 4 TRACE: see Optional Feature; reads 0 when the feature is compiled out.
  - 5-7: unmapped. Reads return 0; writes have no effect.
- Writes to read-only registers have no effect.

Reads:
- Purely combinational from dataadr. Zero latency, so the single-cycle core sees the load in the same cycle.
- RAM read returns the pre-write value when a write to the same word occurs that cycle.

RAM writes:
- memwrite=1 with dataadr[31]=0 writes RAM[index] <= writedata at the rising edge.

TX FIFO:
- Push: memwrite=1 to TXDATA.
- Pop: tx_valid && tx_ready.
- tx_valid = ~empty; tx_data = head word. tx_data is 0 when empty.
- Push when full and no pop in the same cycle: word dropped, overflow set (sticky until reset).
- Push and pop in the same cycle when full: both occur, count unchanged, no overflow.
- Push and pop in the same cycle when empty: push only. A word is never visible and popped in the cycle it is written.
- Read/write pointers wrap modulo FIFO_DEPTH. Count ranges 0..FIFO_DEPTH.

CYCLES:
- Increments every cycle reset is low.
- Wraps from 0xFFFFFFFF to 0.
- Value read in a cycle is the pre-increment value.

DONE:
- done stays 1 until reset.
- A later DONE write updates result; done remains 1.

Reset:
- Effective at the next rising edge, including mid-transfer. It clears the FIFO (tx_valid=0, tx_data=0), overflow, the cycle counter, done=0, result=0, and trace state.
- RAM contents are not cleared by reset.
- Reset has priority over a simultaneous memwrite; that write is discarded.

Optional Feature:
Macro DMEM_WRITE_TRACE_EN.
- Defined: TRACE register (MMIO index 4) reads {last RAM write word index [15:0], RAM write count [15:0]}.
  - Every RAM write increments the 16-bit count, which wraps at 0xFFFF, and records the index.
  - MMIO writes are not counted.
  - Reset clears both fields.
- Undefined: no trace logic is built; TRACE reads 0.

Test Plan:
1. Reset for 2 cycles, then sw 34 to 0x54 and lw from 0x54 -> readdata=34 in the same cycle. Reset high on an edge with memwrite=1 -> that write is discarded.
2. tx_ready=0; push 0xA1..0xA9 (9 words) to 0x80000000 -> STATUS=0x0806 (count 8, full, overflow). Then tx_ready=1 -> tx_data sequence A1..A8, one per cycle, then tx_valid=0 and STATUS=0x0005.
3. FIFO full with tx_ready=1 and a push in the same cycle -> count stays 8, overflow stays 0, pushed word emerges last.
4. Release reset and read 0x80000008 after 10 cycles -> 10. Force the counter to 0xFFFFFFFF -> next cycle reads 0.
5. Write 0x1234 to 0x8000000C -> done=1 and result=0x1234 next cycle. A second write of 0x5 -> result=5, done=1. Reset -> done=0, result=0.
6. With DMEM_WRITE_TRACE_EN: RAM writes to 0x10, 0x14, 0x114 (RAM_WORDS=64, so 0x114 maps to index 5) -> TRACE=0x00050003. Without the macro -> TRACE reads 0.
